ram_lsu_ctrl: RTL and testbench

RAM_LSU_CTRL -- requirements
Module: ram_lsu_ctrl

---
 rtl/ram_lsu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ram_lsu_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_lsu_ctrl.sv
// Load/store unit controller for a single-port-per-direction word RAM.
// Handles byte/half/word accesses, sub-word stores by read-modify-write, and alignment/range errors.
module ram_lsu_ctrl #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [31:0]   req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_wdata,

  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,

  output logic          ram_w_en,
  output logic [AW-1:0] ram_w_addr_o,
  output logic [DW-1:0] ram_w_data_o,
  output logic          ram_r_en,
  output logic [AW-1:0] ram_r_addr_o,
  input  logic [DW-1:0] ram_r_data_i
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    DATA,
    WR,
    RSP
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t        state;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [15:0]   wdata_q;
  logic [1:0]    lane_q;
  logic [AW-1:0] addr_q;

  logic          req_err;
  logic [DW-1:0] shifted;
  logic [DW-1:0] load_val;
  logic [DW-1:0] merged;

  assign req_err = (req_size == 2'b11)
                || (req_size == SIZE_HALF && req_addr[0])
                || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
                || (|req_addr[31:AW+2]);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    shifted  = ram_r_data_i >> {lane_q, 3'b000};
    load_val = ram_r_data_i;
    case (size_q)
      SIZE_BYTE: load_val = uns_q ? {{(DW-8){1'b0}}, shifted[7:0]}
                                  : {{(DW-8){shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_val = uns_q ? {{(DW-16){1'b0}}, shifted[15:0]}
                                  : {{(DW-16){shifted[15]}}, shifted[15:0]};
      default:   load_val = ram_r_data_i;
    endcase
  end

  // Sub-word store: splice the new lane into the word just read, leaving other lanes intact.
  always_comb begin
    merged = ram_r_data_i;
    if (size_q == SIZE_BYTE) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else                     merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
      ram_w_en     <= 1'b0;
      ram_w_addr_o <= '0;
      ram_w_data_o <= '0;
      ram_r_en     <= 1'b0;
      ram_r_addr_o <= '0;
      we_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      lane_q       <= '0;
      addr_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            wdata_q   <= req_wdata[15:0];
            lane_q    <= req_addr[1:0];
            addr_q    <= req_addr[AW+1:2];
            if (req_err) begin
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we && req_size == SIZE_WORD) begin
              state        <= WR;
              ram_w_en     <= 1'b1;
              ram_w_addr_o <= req_addr[AW+1:2];
              ram_w_data_o <= req_wdata;
            end else begin
              // Loads and sub-word stores both start with a RAM read.
              state        <= RD;
              ram_r_en     <= 1'b1;
              ram_r_addr_o <= req_addr[AW+1:2];
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD: begin
          ram_r_en <= 1'b0;
          state    <= DATA;
        end
        DATA: begin
          if (we_q) begin
            state        <= WR;
            ram_w_en     <= 1'b1;
            ram_w_addr_o <= addr_q;
            ram_w_data_o <= merged;
          end else begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_val;
          end
        end
        WR: begin
          ram_w_en  <= 1'b0;
          state     <= RSP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_lsu_ctrl.sv
// Scoreboard bench for ram_lsu_ctrl: a behavioural RAM, a memory model predicting every response,
// and a negedge monitor checking latency, data, error flag, RAM pulse counts and response stability.
module tb_ram_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_w_en, ram_r_en;
  logic [11:0] ram_w_addr, ram_r_addr;
  logic [31:0] ram_w_data, ram_r_data;

  ram_lsu_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_w_en(ram_w_en), .ram_w_addr_o(ram_w_addr), .ram_w_data_o(ram_w_data),
    .ram_r_en(ram_r_en), .ram_r_addr_o(ram_r_addr), .ram_r_data_i(ram_r_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [4096];
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
    if (ram_r_en) ram_r_data <= mem[ram_r_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          r0;
    int          w0;
    int          exp_r;
    int          exp_w;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [4096];
  int          n_checks = 0;
  int          n_pass = 0;
  int          r_cnt = 0;
  int          w_cnt = 0;
  logic        prev_valid = 1'b0;
  logic        prev_err = 1'b0;
  logic [31:0] prev_rdata = '0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = word >> (8 * lane);
    case (size)
      2'd0:    return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'd1:    return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] mask;
    if (size == 2'd2) return wdata;
    mask = ((size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * lane);
    return (word & ~mask) | ((wdata << (8 * lane)) & mask);
  endfunction

  // Response monitor: samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (ram_r_en) r_cnt <= r_cnt + 1;
      if (ram_w_en) w_cnt <= w_cnt + 1;
      if (rsp_valid) check("req_ready_low_in_rsp", {31'h0, req_ready}, 32'h0);
      if (rsp_valid && prev_valid) begin
        check("rsp_rdata_stable", rsp_rdata, prev_rdata);
        check("rsp_err_stable", {31'h0, rsp_err}, {31'h0, prev_err});
      end
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) check("unexpected_rsp", 32'h1, 32'h0);
        else check("rsp_latency", cyc - sb[0].acc, sb[0].lat);
      end
      if (rsp_valid && rsp_ready && sb.size() != 0) begin
        check("rsp_rdata", rsp_rdata, sb[0].rdata);
        check("rsp_err", {31'h0, rsp_err}, {31'h0, sb[0].err});
        check("ram_r_pulses", r_cnt - sb[0].r0, sb[0].exp_r);
        check("ram_w_pulses", w_cnt - sb[0].w0, sb[0].exp_w);
        last_rdata <= rsp_rdata;
        last_err   <= rsp_err;
        void'(sb.pop_front());
      end
      prev_valid <= rsp_valid;
      prev_rdata <= rsp_rdata;
      prev_err   <= rsp_err;
    end
  end

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata);
    exp_t        e;
    int          n;
    logic [11:0] wa;
    logic        bad;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_send", {31'h0, req_ready}, 32'h1);
    wa  = addr[13:2];
    bad = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)
       || (addr[31:14] != 18'h0);
    e.rdata = '0;
    e.err   = bad;
    e.acc   = cyc;
    e.r0    = r_cnt;
    e.w0    = w_cnt;
    if (bad) begin
      e.lat = 1; e.exp_r = 0; e.exp_w = 0;
    end else if (!we) begin
      e.lat = 3; e.exp_r = 1; e.exp_w = 0;
      e.rdata = model_load(model_mem[wa], addr[1:0], size, uns);
    end else if (size == 2'd2) begin
      e.lat = 2; e.exp_r = 0; e.exp_w = 1;
      model_mem[wa] = wdata;
    end else begin
      e.lat = 4; e.exp_r = 1; e.exp_w = 1;
      model_mem[wa] = model_merge(model_mem[wa], addr[1:0], size, wdata);
    end
    sb.push_back(e);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("rsp_timeout", 32'h0, 32'h1);
      sb.delete();
    end
  endtask

  task automatic op(input logic we, input logic [31:0] addr, input logic [1:0] size,
                    input logic uns, input logic [31:0] wdata);
    send(we, addr, size, uns, wdata);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved;
    int          w_snap;
    logic [1:0]  sz;
    logic [1:0]  ln;

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
    #3;
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_ram_w_en", {31'h0, ram_w_en}, 32'h0);
    check("rst_ram_r_en", {31'h0, ram_r_en}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_ram_w_addr", {20'h0, ram_w_addr}, 32'h0);
    check("rst_ram_r_addr", {20'h0, ram_r_addr}, 32'h0);
    check("rst_ram_w_data", ram_w_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("req_ready_after_rst", {31'h0, req_ready}, 32'h1);

    op(1'b1, 32'h14, 2'd2, 1'b0, 32'h1122_3344);
    check("mem5_word_store", mem[5], 32'h1122_3344);
    op(1'b0, 32'h16, 2'd0, 1'b0, 32'h0);
    check("ld_byte_0x16", last_rdata, 32'h0000_0022);
    op(1'b1, 32'h15, 2'd0, 1'b0, 32'h0000_00AB);
    check("mem5_byte_rmw", mem[5], 32'h1122_AB44);
    check("st_byte_err", {31'h0, last_err}, 32'h0);

    op(1'b1, 32'h20, 2'd2, 1'b0, 32'hDEAD_BEEF);
    op(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
    check("ld_word_0x20", last_rdata, 32'hDEAD_BEEF);

    op(1'b1, 32'h14, 2'd2, 1'b0, 32'h8000_0000);
    op(1'b0, 32'h16, 2'd1, 1'b0, 32'h0);
    check("ld_half_signed", last_rdata, 32'hFFFF_8000);
    op(1'b0, 32'h16, 2'd1, 1'b1, 32'h0);
    check("ld_half_unsigned", last_rdata, 32'h0000_8000);
    op(1'b0, 32'h17, 2'd0, 1'b0, 32'h0);
    check("ld_byte_lane3_signed", last_rdata, 32'hFFFF_FF80);

    op(1'b1, 32'h22, 2'd1, 1'b0, 32'h1234_BEEF);
    op(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
    check("ld_after_half_store", last_rdata, 32'hBEEF_BEEF);

    op(1'b0, 32'h02, 2'd2, 1'b0, 32'h0);
    check("err_misaligned_word", {31'h0, last_err}, 32'h1);
    op(1'b0, 32'h4000, 2'd2, 1'b0, 32'h0);
    check("err_range_load", {31'h0, last_err}, 32'h1);
    op(1'b1, 32'h4000, 2'd0, 1'b0, 32'hFF);
    op(1'b0, 32'h10, 2'd3, 1'b0, 32'h0);
    op(1'b1, 32'h11, 2'd1, 1'b0, 32'h5555);
    check("mem5_after_errors", mem[5], 32'h8000_0000);

    // Held response plus ignored requests while busy.
    rsp_ready = 1'b0;
    send(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 2'd2; req_wdata = 32'h0;
    repeat (8) @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_done();
    check("stall_rdata", last_rdata, 32'hBEEF_BEEF);
    check("stall_no_write", mem[8], 32'hBEEF_BEEF);

    for (int i = 0; i < 8; i++) op(1'b1, 32'h40 + 4 * i, 2'd2, 1'b0, $urandom);
    for (int i = 0; i < 30; i++) begin
      sz = 2'($urandom_range(0, 2));
      ln = (sz == 2'd0) ? 2'($urandom_range(0, 3)) : (sz == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
      op(1'($urandom_range(0, 1)), 32'h40 + 4 * $urandom_range(0, 7) + {30'h0, ln}, sz,
         1'($urandom_range(0, 1)), $urandom);
    end

    // Reset during the DATA phase of a sub-word store.
    saved = model_mem[5];
    send(1'b1, 32'h15, 2'd0, 1'b0, 32'h0000_00CD);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_w_en", {31'h0, ram_w_en}, 32'h0);
    check("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("abort_req_ready", {31'h0, req_ready}, 32'h0);
    sb.delete();
    model_mem[5] = saved;
    w_snap = w_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_req_ready_after", {31'h0, req_ready}, 32'h1);
    check("abort_no_write", w_cnt, w_snap);
    check("abort_mem5", mem[5], saved);
    op(1'b0, 32'h14, 2'd2, 1'b0, 32'h0);
    check("abort_reload", last_rdata, 32'h8000_0000);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
